// File: rtl/risc_core.sv
// Single-cycle 32-bit load/store RISC core with internal instruction and data memories.
// Executes one instruction per enabled clock and freezes after HALT until reset.
module risc_core #(
  parameter int unsigned ADDR_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        halt,
  output logic [31:0] reg0,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [31:0] reg3,
  output logic [31:0] reg4,
  output logic [31:0] reg5,
  output logic [31:0] reg6,
  output logic [31:0] reg7,
  output logic [31:0] reg8,
  output logic [31:0] reg9,
  output logic [31:0] reg10,
  output logic [31:0] reg11,
  output logic [31:0] reg12,
  output logic [31:0] reg13,
  output logic [31:0] reg14,
  output logic [31:0] reg15,
  output logic [31:0] reg16,
  output logic [31:0] reg17,
  output logic [31:0] reg18,
  output logic [31:0] reg19,
  output logic [31:0] reg20,
  output logic [31:0] reg21,
  output logic [31:0] reg22,
  output logic [31:0] reg23,
  output logic [31:0] reg24,
  output logic [31:0] reg25,
  output logic [31:0] reg26,
  output logic [31:0] reg27,
  output logic [31:0] reg28,
  output logic [31:0] reg29,
  output logic [31:0] reg30,
  output logic [31:0] reg31
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = $clog2(ADDR_DEPTH);
  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned IW   = 15;

  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_MOVA = 7'b1000000;
  localparam logic [6:0] OP_MOVB = 7'b0001100;
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101;
  localparam logic [6:0] OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001;
  localparam logic [6:0] OP_XOR  = 7'b0001010;
  localparam logic [6:0] OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_ADI  = 7'b0100010;
  localparam logic [6:0] OP_SBI  = 7'b0100101;
  localparam logic [6:0] OP_ANI  = 7'b0101000;
  localparam logic [6:0] OP_ORI  = 7'b0101001;
  localparam logic [6:0] OP_XRI  = 7'b0101010;
  localparam logic [6:0] OP_LSR  = 7'b0001101;
  localparam logic [6:0] OP_LSL  = 7'b0001110;
  localparam logic [6:0] OP_SLT  = 7'b1100101;
  localparam logic [6:0] OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000;
  localparam logic [6:0] OP_JMR  = 7'b1110000;
  localparam logic [6:0] OP_JMP  = 7'b1101000;
  localparam logic [6:0] OP_BZ   = 7'b1100000;
  localparam logic [6:0] OP_BNZ  = 7'b1001000;
  localparam logic [6:0] OP_JML  = 7'b0110000;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  // Memory contents come from the environment (preload image); reset never clears them.
  logic [DW-1:0] imem [ADDR_DEPTH];
  logic [DW-1:0] dmem [ADDR_DEPTH];

  logic [NREG-1:0][DW-1:0] rf_q;
  logic [AW-1:0]           pc_q, pc_d;
  logic                    halt_q, halt_d;

  logic [DW-1:0] ir;
  logic [6:0]    op;
  logic [RW-1:0] dr, sa, sb;
  logic [IW-1:0] imm;
  logic [RW-1:0] sh;
  logic [DW-1:0] op_a, op_b, imm_se, imm_ze;
  logic [AW-1:0] pc_inc, pc_br, dm_addr;
  logic          step;
  logic          rf_we;
  logic [DW-1:0] rf_wd;
  logic          dm_we;

  // Instruction field decode
  assign ir      = imem[pc_q];
  assign op      = ir[31:25];
  assign dr      = ir[24:20];
  assign sa      = ir[19:15];
  assign sb      = ir[14:10];
  assign imm     = ir[14:0];
  assign sh      = ir[4:0];

  // R0 is never written, so reading rf_q[0] always yields zero
  assign op_a    = rf_q[sa];
  assign op_b    = rf_q[sb];
  assign imm_se  = {{(DW-IW){imm[IW-1]}}, imm};
  assign imm_ze  = {{(DW-IW){1'b0}}, imm};
  assign pc_inc  = pc_q + AW'(1);
  assign pc_br   = pc_inc + AW'(imm_se);
  assign dm_addr = AW'(op_a);
  assign step    = en & ~halt_q;

  // Execute: next PC, register write-back and store request
  always_comb begin
    pc_d   = pc_q;
    halt_d = halt_q;
    rf_we  = 1'b0;
    rf_wd  = '0;
    dm_we  = 1'b0;
    if (step) begin
      pc_d = pc_inc;
      case (op)
        OP_MOVA: begin rf_we = 1'b1; rf_wd = op_a;           end
        OP_MOVB: begin rf_we = 1'b1; rf_wd = op_b;           end
        OP_ADD:  begin rf_we = 1'b1; rf_wd = op_a + op_b;    end
        OP_SUB:  begin rf_we = 1'b1; rf_wd = op_a - op_b;    end
        OP_AND:  begin rf_we = 1'b1; rf_wd = op_a & op_b;    end
        OP_OR:   begin rf_we = 1'b1; rf_wd = op_a | op_b;    end
        OP_XOR:  begin rf_we = 1'b1; rf_wd = op_a ^ op_b;    end
        OP_NOT:  begin rf_we = 1'b1; rf_wd = ~op_a;          end
        OP_ADI:  begin rf_we = 1'b1; rf_wd = op_a + imm_se;  end
        OP_SBI:  begin rf_we = 1'b1; rf_wd = op_a - imm_se;  end
        OP_ANI:  begin rf_we = 1'b1; rf_wd = op_a & imm_ze;  end
        OP_ORI:  begin rf_we = 1'b1; rf_wd = op_a | imm_ze;  end
        OP_XRI:  begin rf_we = 1'b1; rf_wd = op_a ^ imm_ze;  end
        OP_LSR:  begin rf_we = 1'b1; rf_wd = op_a >> sh;     end
        OP_LSL:  begin rf_we = 1'b1; rf_wd = op_a << sh;     end
        OP_SLT:  begin
          rf_we = 1'b1;
          rf_wd = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        end
        OP_LD:   begin rf_we = 1'b1; rf_wd = dmem[dm_addr];  end
        OP_ST:   dm_we = 1'b1;
        OP_JMR:  pc_d = dm_addr;
        OP_JMP:  pc_d = pc_br;
        OP_BZ:   if (op_a == '0) pc_d = pc_br;
        OP_BNZ:  if (op_a != '0) pc_d = pc_br;
        OP_JML:  begin
          rf_we = 1'b1;
          rf_wd = {{(DW-AW){1'b0}}, pc_inc};
          pc_d  = pc_br;
        end
        OP_HALT: begin
          pc_d   = pc_q;
          halt_d = 1'b1;
        end
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      halt_q <= 1'b0;
      rf_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
      if (rf_we && (dr != '0)) rf_q[dr] <= rf_wd;
    end
  end

  // Data memory write port; reset leaves contents intact
  always_ff @(posedge clk) begin
    if (dm_we) dmem[dm_addr] <= op_b;
  end

  assign halt  = halt_q;
  assign reg0  = rf_q[0];
  assign reg1  = rf_q[1];
  assign reg2  = rf_q[2];
  assign reg3  = rf_q[3];
  assign reg4  = rf_q[4];
  assign reg5  = rf_q[5];
  assign reg6  = rf_q[6];
  assign reg7  = rf_q[7];
  assign reg8  = rf_q[8];
  assign reg9  = rf_q[9];
  assign reg10 = rf_q[10];
  assign reg11 = rf_q[11];
  assign reg12 = rf_q[12];
  assign reg13 = rf_q[13];
  assign reg14 = rf_q[14];
  assign reg15 = rf_q[15];
  assign reg16 = rf_q[16];
  assign reg17 = rf_q[17];
  assign reg18 = rf_q[18];
  assign reg19 = rf_q[19];
  assign reg20 = rf_q[20];
  assign reg21 = rf_q[21];
  assign reg22 = rf_q[22];
  assign reg23 = rf_q[23];
  assign reg24 = rf_q[24];
  assign reg25 = rf_q[25];
  assign reg26 = rf_q[26];
  assign reg27 = rf_q[27];
  assign reg28 = rf_q[28];
  assign reg29 = rf_q[29];
  assign reg30 = rf_q[30];
  assign reg31 = rf_q[31];

endmodule

// File: tb/tb_risc_core.sv
// Bench for risc_core: directed sequences, an ALU vector table, GCD runs and
// random programs checked in lockstep against an instruction-level model.
module tb_risc_core;

  localparam int DEPTH = 2048;
  localparam int MASK  = DEPTH - 1;

  localparam logic [6:0] OP_NOP  = 7'b0000000, OP_MOVA = 7'b1000000, OP_MOVB = 7'b0001100;
  localparam logic [6:0] OP_ADD  = 7'b0000010, OP_SUB  = 7'b0000101, OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001, OP_XOR  = 7'b0001010, OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_ADI  = 7'b0100010, OP_SBI  = 7'b0100101, OP_ANI  = 7'b0101000;
  localparam logic [6:0] OP_ORI  = 7'b0101001, OP_XRI  = 7'b0101010, OP_LSR  = 7'b0001101;
  localparam logic [6:0] OP_LSL  = 7'b0001110, OP_SLT  = 7'b1100101, OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000, OP_JMR  = 7'b1110000, OP_JMP  = 7'b1101000;
  localparam logic [6:0] OP_BZ   = 7'b1100000, OP_BNZ  = 7'b1001000, OP_JML  = 7'b0110000;
  localparam logic [6:0] OP_HLT  = 7'b1111111;

  localparam logic [6:0] RAND_OPS [0:22] = '{
    OP_NOP, OP_MOVA, OP_MOVB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADI, OP_SBI,
    OP_ANI, OP_ORI, OP_XRI, OP_LSR, OP_LSL, OP_SLT, OP_LD, OP_ST, OP_BZ, OP_BNZ, OP_JML,
    7'b0000001};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic halt;
  logic [31:0][31:0] r;

  risc_core dut (
    .clk(clk), .rst_n(rst_n), .en(en), .halt(halt),
    .reg0(r[0]),   .reg1(r[1]),   .reg2(r[2]),   .reg3(r[3]),
    .reg4(r[4]),   .reg5(r[5]),   .reg6(r[6]),   .reg7(r[7]),
    .reg8(r[8]),   .reg9(r[9]),   .reg10(r[10]), .reg11(r[11]),
    .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
    .reg16(r[16]), .reg17(r[17]), .reg18(r[18]), .reg19(r[19]),
    .reg20(r[20]), .reg21(r[21]), .reg22(r[22]), .reg23(r[23]),
    .reg24(r[24]), .reg25(r[25]), .reg26(r[26]), .reg27(r[27]),
    .reg28(r[28]), .reg29(r[29]), .reg30(r[30]), .reg31(r[31]));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Instruction-level reference model
  logic [31:0] m_rf [32];
  logic [31:0] m_dmem [int];
  logic [31:0] m_imem [DEPTH];
  int          m_pc;
  bit          m_halt;

  logic [31:0] prog [$];

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [14:0] low;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ri(logic [6:0] op, int dr, int sa, int imm);
    return {op, 5'(dr), 5'(sa), 15'(imm)};
  endfunction

  function automatic logic [31:0] rr(logic [6:0] op, int dr, int sa, int sb);
    return {op, 5'(dr), 5'(sa), 5'(sb), 10'd0};
  endfunction

  task automatic put_const(input int rd, input logic [31:0] v);
    prog.push_back(ri(OP_ORI, rd, 0, int'(v[31:30])));
    prog.push_back(ri(OP_LSL, rd, rd, 15));
    prog.push_back(ri(OP_ORI, rd, rd, int'(v[29:15])));
    prog.push_back(ri(OP_LSL, rd, rd, 15));
    prog.push_back(ri(OP_ORI, rd, rd, int'(v[14:0])));
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    dut.imem[addr] = w;
    m_imem[addr]   = w;
  endtask

  // Fill unused slots with HALT so stray control flow stops the core
  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) put_word(i, {OP_HLT, 25'd0});
    for (int i = 0; i < prog.size(); i++) put_word(i, prog[i]);
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_pc = 0;
    m_halt = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_halt(input string name, input int budget, output int cycles);
    en = 1'b1;
    cycles = 0;
    while (!halt && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    en = 1'b0;
    if (!halt) check({name, " halt_timeout"}, {31'd0, halt}, 32'd1);
  endtask

  function automatic void m_step();
    logic [31:0] ir, a, b, se, ze, res;
    logic [6:0]  op;
    int          dr, nxt, tgt, npc;
    bit          wr;
    ir  = m_imem[m_pc];
    op  = ir[31:25];
    dr  = int'(ir[24:20]);
    a   = m_rf[int'(ir[19:15])];
    b   = m_rf[int'(ir[14:10])];
    se  = 32'($signed(ir[14:0]));
    ze  = {17'd0, ir[14:0]};
    nxt = (m_pc + 1) % DEPTH;
    tgt = (nxt + int'($signed(ir[14:0]))) & MASK;
    npc = nxt;
    wr  = 1'b1;
    res = '0;
    case (op)
      OP_MOVA: res = a;
      OP_MOVB: res = b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_ADI:  res = a + se;
      OP_SBI:  res = a - se;
      OP_ANI:  res = a & ze;
      OP_ORI:  res = a | ze;
      OP_XRI:  res = a ^ ze;
      OP_LSR:  res = a >> ir[4:0];
      OP_LSL:  res = a << ir[4:0];
      OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_LD:   res = m_dmem.exists(int'(a) & MASK) ? m_dmem[int'(a) & MASK] : 32'hxxxxxxxx;
      OP_ST:   begin wr = 1'b0; m_dmem[int'(a) & MASK] = b; end
      OP_JMR:  begin wr = 1'b0; npc = int'(a) & MASK; end
      OP_JMP:  begin wr = 1'b0; npc = tgt; end
      OP_BZ:   begin wr = 1'b0; if (a == 0) npc = tgt; end
      OP_BNZ:  begin wr = 1'b0; if (a != 0) npc = tgt; end
      OP_JML:  begin res = 32'(nxt); npc = tgt; end
      OP_HLT:  begin wr = 1'b0; m_halt = 1'b1; npc = m_pc; end
      default: wr = 1'b0;
    endcase
    if (wr && dr != 0) m_rf[dr] = res;
    m_pc = npc;
  endfunction

  function automatic int gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  int cyc, post, k, ga, gb;
  logic [6:0] rop;
  int rdr, rsa, rimm;

  initial begin
    // Reset with en low: core must not advance
    prog.delete();
    prog.push_back(ri(OP_ADI, 1, 0, 1));
    load_prog();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    step(5);
    check("reset halt", {31'd0, halt}, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("reset reg%0d", i), r[i], 32'd0);
    en = 1'b1;
    step(1);
    en = 1'b0;
    check("reset first_instr_at_pc0", r[1], 32'd1);

    // ADI/ADI/ADD/HALT timing
    prog.delete();
    prog.push_back(ri(OP_ADI, 1, 0, 5));
    prog.push_back(ri(OP_ADI, 2, 0, -3));
    prog.push_back(rr(OP_ADD, 3, 1, 2));
    prog.push_back({OP_HLT, 25'd0});
    load_prog();
    do_reset();
    en = 1'b1;
    step(3);
    check("add3 halt_before", {31'd0, halt}, 32'd0);
    step(1);
    check("add3 halt", {31'd0, halt}, 32'd1);
    check("add3 reg1", r[1], 32'd5);
    check("add3 reg2", r[2], 32'hFFFFFFFD);
    check("add3 reg3", r[3], 32'd2);
    step(3);
    check("add3 halt_sticky", {31'd0, halt}, 32'd1);
    en = 1'b0;

    // Store/load, address wrap, R0 write discard
    prog.delete();
    prog.push_back(ri(OP_ADI, 1, 0, 7));
    prog.push_back(ri(OP_ADI, 2, 0, 32'h1234));
    prog.push_back(rr(OP_ST, 0, 1, 2));
    prog.push_back(ri(OP_LD, 4, 1, 0));
    prog.push_back(ri(OP_ADI, 0, 0, 9));
    prog.push_back(ri(OP_ADI, 3, 0, 32'h0807));
    prog.push_back(ri(OP_LD, 5, 3, 0));
    load_prog();
    do_reset();
    run_to_halt("stld", 20, cyc);
    check("stld reg4", r[4], 32'h1234);
    check("stld reg5_wrap", r[5], 32'h1234);
    check("stld reg0", r[0], 32'd0);
    check("stld cycles", 32'(cyc), 32'd8);

    // Branches, JMP, JML, JMR
    prog.delete();
    prog.push_back(ri(OP_ADI, 1, 0, 0));
    prog.push_back(ri(OP_BZ, 0, 1, 1));
    prog.push_back(ri(OP_ADI, 6, 0, 1));
    prog.push_back(ri(OP_BNZ, 0, 1, 1));
    prog.push_back(ri(OP_ADI, 7, 0, 2));
    prog.push_back(ri(OP_JMP, 0, 0, 4));
    for (int i = 6; i < 10; i++) prog.push_back(ri(OP_ADI, 8, 0, 3));
    prog.push_back(ri(OP_JML, 5, 0, 2));
    prog.push_back(ri(OP_ADI, 9, 0, 4));
    prog.push_back(ri(OP_ADI, 9, 0, 4));
    prog.push_back(ri(OP_ADI, 10, 0, 5));
    prog.push_back(ri(OP_ADI, 11, 0, 17));
    prog.push_back(ri(OP_JMR, 0, 11, 0));
    prog.push_back(ri(OP_ADI, 12, 0, 6));
    load_prog();
    do_reset();
    en = 1'b1;
    step(9);
    check("br halt_before", {31'd0, halt}, 32'd0);
    step(1);
    en = 1'b0;
    check("br halt", {31'd0, halt}, 32'd1);
    check("br reg5_jml", r[5], 32'd11);
    check("br reg6_bz_skipped", r[6], 32'd0);
    check("br reg7_bnz_fallthru", r[7], 32'd2);
    check("br reg8_jmp_skipped", r[8], 32'd0);
    check("br reg9_jml_skipped", r[9], 32'd0);
    check("br reg10_jml_target", r[10], 32'd5);
    check("br reg12_jmr_skipped", r[12], 32'd0);

    // PC wrap 2047 -> 0
    prog.delete();
    prog.push_back(ri(OP_BNZ, 0, 2, 1));
    prog.push_back(ri(OP_JMP, 0, 0, 2044));
    load_prog();
    put_word(2046, ri(OP_ADI, 1, 0, 1));
    put_word(2047, ri(OP_ADI, 2, 0, 2));
    do_reset();
    run_to_halt("wrap", 20, cyc);
    check("wrap cycles", 32'(cyc), 32'd6);
    check("wrap reg1", r[1], 32'd1);
    check("wrap reg2", r[2], 32'd2);

    // en freeze, async reset mid-run, halt sticky
    prog.delete();
    for (int i = 0; i < 20; i++) prog.push_back(ri(OP_ADI, 1, 1, 1));
    load_prog();
    do_reset();
    en = 1'b1;
    step(5);
    check("en run5", r[1], 32'd5);
    en = 1'b0;
    step(3);
    check("en frozen", r[1], 32'd5);
    check("en frozen_halt", {31'd0, halt}, 32'd0);
    en = 1'b1;
    step(2);
    check("en resume", r[1], 32'd7);
    rst_n = 1'b0;
    #1;
    check("async reg1", r[1], 32'd0);
    rst_n = 1'b1;
    step(2);
    check("async restart_pc0", r[1], 32'd2);
    en = 1'b0;
    run_to_halt("cnt", 40, cyc);
    check("cnt reg1", r[1], 32'd20);
    en = 1'b1;
    step(3);
    en = 1'b0;
    check("cnt halt_sticky", {31'd0, halt}, 32'd1);
    check("cnt frozen_after_halt", r[1], 32'd20);
    rst_n = 1'b0;
    #1;
    check("cnt async_clears_halt", {31'd0, halt}, 32'd0);
    rst_n = 1'b1;

    // ALU vector table: R1=a, R2=b, op R3,R1,low, HALT
    vt.push_back('{"ADD",    OP_ADD,  32'd5,        32'hFFFFFFFD, 15'h0800, 32'd2});
    vt.push_back('{"SUB",    OP_SUB,  32'd3,        32'd5,        15'h0800, 32'hFFFFFFFE});
    vt.push_back('{"AND",    OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 15'h0800, 32'hF000F000});
    vt.push_back('{"OR",     OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 15'h0800, 32'hFFF0FFF0});
    vt.push_back('{"XOR",    OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 15'h0800, 32'h0FF00FF0});
    vt.push_back('{"NOT",    OP_NOT,  32'hF0F0F0F0, 32'd0,        15'h0000, 32'h0F0F0F0F});
    vt.push_back('{"MOVA",   OP_MOVA, 32'hDEADBEEF, 32'd1,        15'h0800, 32'hDEADBEEF});
    vt.push_back('{"MOVB",   OP_MOVB, 32'd1,        32'h12345678, 15'h0800, 32'h12345678});
    vt.push_back('{"ADI",    OP_ADI,  32'd10,       32'd0,        15'h7FFF, 32'd9});
    vt.push_back('{"SBI",    OP_SBI,  32'd10,       32'd0,        15'h4000, 32'h0000400A});
    vt.push_back('{"ANI",    OP_ANI,  32'hFFFFFFFF, 32'd0,        15'h7FFF, 32'h00007FFF});
    vt.push_back('{"ORI",    OP_ORI,  32'h80000000, 32'd0,        15'h4001, 32'h80004001});
    vt.push_back('{"XRI",    OP_XRI,  32'hFFFF0000, 32'd0,        15'h7FFF, 32'hFFFF7FFF});
    vt.push_back('{"LSR",    OP_LSR,  32'hFFFFFFFF, 32'd0,        15'd28,   32'h0000000F});
    vt.push_back('{"LSL",    OP_LSL,  32'hFFFFFFFF, 32'd0,        15'd4,    32'hFFFFFFF0});
    vt.push_back('{"SLT1",   OP_SLT,  32'hFFFFFFFF, 32'd1,        15'h0800, 32'd1});
    vt.push_back('{"SLT0",   OP_SLT,  32'd1,        32'hFFFFFFFF, 15'h0800, 32'd0});
    vt.push_back('{"SLTMIN", OP_SLT,  32'h80000000, 32'h7FFFFFFF, 15'h0800, 32'd1});
    vt.push_back('{"ADDOVF", OP_ADD,  32'hFFFFFFFF, 32'd1,        15'h0800, 32'd0});
    vt.push_back('{"BADOP",  7'b0000001, 32'd7,     32'd9,        15'h0800, 32'd0});
    for (int v = 0; v < vt.size(); v++) begin
      prog.delete();
      put_const(1, vt[v].a);
      put_const(2, vt[v].b);
      prog.push_back({vt[v].op, 5'd3, 5'd1, vt[v].low});
      load_prog();
      do_reset();
      run_to_halt(vt[v].name, 20, cyc);
      check({"alu ", vt[v].name}, r[3], vt[v].exp);
    end

    // GCD by repeated subtraction, result stored and reloaded via DMEM
    for (int g = 0; g < 5; g++) begin
      ga = (g == 0) ? 48 : int'($urandom_range(1, 200));
      gb = (g == 0) ? 18 : int'($urandom_range(1, 200));
      prog.delete();
      prog.push_back(ri(OP_ADI, 1, 0, ga));
      prog.push_back(ri(OP_ADI, 2, 0, gb));
      prog.push_back(rr(OP_SUB, 3, 1, 2));
      prog.push_back(ri(OP_BZ, 0, 3, 6));
      prog.push_back(rr(OP_SLT, 4, 1, 2));
      prog.push_back(ri(OP_BNZ, 0, 4, 2));
      prog.push_back(rr(OP_SUB, 1, 1, 2));
      prog.push_back(ri(OP_JMP, 0, 0, -6));
      prog.push_back(rr(OP_SUB, 2, 2, 1));
      prog.push_back(ri(OP_JMP, 0, 0, -8));
      prog.push_back(rr(OP_ST, 0, 0, 1));
      prog.push_back(ri(OP_LD, 6, 0, 0));
      load_prog();
      do_reset();
      run_to_halt($sformatf("gcd%0d", g), 5000, cyc);
      check($sformatf("gcd(%0d,%0d) reg1", ga, gb), r[1], 32'(gcd(ga, gb)));
      check($sformatf("gcd(%0d,%0d) reg6", ga, gb), r[6], 32'(gcd(ga, gb)));
      en = 1'b1;
      step(4);
      en = 1'b0;
      check($sformatf("gcd%0d halt_stays", g), {31'd0, halt}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("gcd async_reset_halt", {31'd0, halt}, 32'd0);
    rst_n = 1'b1;

    // Random programs in lockstep with the model, random en gaps
    m_dmem.delete();
    for (int p = 0; p < 10; p++) begin
      prog.delete();
      for (int i = 1; i < 7; i++) prog.push_back(ri(OP_ADI, i, 0, int'($urandom_range(0, 32767))));
      prog.push_back(ri(OP_ADI, 7, 0, int'($urandom_range(0, 4095))));
      prog.push_back(rr(OP_ST, 0, 7, 0));
      for (int i = 0; i < 40; i++) begin
        rop  = RAND_OPS[$urandom_range(0, 22)];
        rdr  = int'($urandom_range(0, 6));
        rsa  = int'($urandom_range(0, 7));
        rimm = int'($urandom_range(0, 32767));
        if (rop == OP_LD || rop == OP_ST) rsa = 7;
        if (rop == OP_BZ || rop == OP_BNZ || rop == OP_JML) rimm = int'($urandom_range(0, 2));
        prog.push_back(ri(rop, rdr, rsa, rimm));
      end
      load_prog();
      do_reset();
      cyc = 0;
      post = 0;
      while (post < 3 && cyc < 300) begin
        en = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        cyc++;
        if (en && !m_halt) m_step();
        k = 0;
        for (int i = 0; i < 32; i++) if (r[i] !== m_rf[i]) k = i;
        check($sformatf("rand p%0d c%0d reg%0d", p, cyc, k), r[k], m_rf[k]);
        check($sformatf("rand p%0d c%0d halt", p, cyc), {31'd0, halt}, {31'd0, m_halt});
        if (m_halt) post++;
      end
      en = 1'b0;
      if (!m_halt) check($sformatf("rand p%0d model_timeout", p), 32'd0, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
